uart_rx_8bit: RTL and testbench

8N1 UART receiver, the downstream consumer of the uart_tx_8bit serial line.
- Oversamples rx at CLKS_PER_BIT clocks per bit and decides each bit by a 3-sample majority vote at mid-bit.
- Outputs each byte with a one-cycle valid strobe.
- Used for loopback checking of the character generator, and as the receive half of the board UART (16 MHz clk, 1 Mbaud).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx_8bit.sv | 143 ++++++++++++++
 tb/tb_uart_rx_8bit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver state encoding, frame width, default bit timing.
package uart_pkg;

  localparam int   DATA_BITS            = 8;
  localparam int   CLKS_PER_BIT_DEFAULT = 16;
  localparam logic IDLE_LEVEL           = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line, plus falling-edge detect on the
// synchronized level. All flops reset to the idle line level so reset never fakes an edge.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rxs,
  output logic fall
);

  logic meta;
  logic rxs_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta  <= IDLE_LEVEL;
      rxs   <= IDLE_LEVEL;
      rxs_q <= IDLE_LEVEL;
    end else begin
      meta  <= rx;
      rxs   <= meta;
      rxs_q <= rxs;
    end
  end

  assign fall = rxs_q & ~rxs;

endmodule

// File: rtl/uart_rx_8bit.sv
// 8N1 UART receiver with mid-bit 3-sample majority vote and one-cycle result strobes.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx_8bit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int MID   = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_DEC  = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 rxs, fall;
  logic                 samp_a, samp_b, vote;
  logic                 at_dec, at_wrap;
  logic                 valid_set, ferr_set;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, perr_set;
`endif

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (rx),
    .rxs  (rxs),
    .fall (fall)
  );

  assign at_dec  = (cnt == CNT_DEC);
  assign at_wrap = (cnt == CNT_LAST);
  // The third sample is the live level at the decision count.
  assign vote    = majority3(samp_a, samp_b, rxs);
  assign busy    = (state != IDLE);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    valid_set  = 1'b0;
    ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set   = 1'b0;
`endif
    case (state)
      IDLE:  if (fall) state_next = START;
      START: begin
        if (at_dec && vote) state_next = IDLE;
        else if (at_wrap)   state_next = DATA;
      end
      DATA: begin
        if (at_wrap && bit_idx == LAST_BIT)
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (at_wrap) state_next = STOP;
`endif
      STOP: begin
        if (at_dec) begin
          if (vote) begin
`ifdef UART_RX_PARITY_EN
            if ((^shift) != par_bit) perr_set  = 1'b1;
            else                     valid_set = 1'b1;
`else
            valid_set = 1'b1;
`endif
            // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
            state_next = IDLE;
          end else begin
            ferr_set   = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK:   if (rxs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      samp_a    <= 1'b0;
      samp_b    <= 1'b0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      valid     <= valid_set;
      frame_err <= ferr_set;

      if (state == IDLE || at_wrap) cnt <= '0;
      else                          cnt <= cnt + 1'b1;

      if (cnt == CNT_PRE) samp_a <= rxs;
      if (cnt == CNT_MID) samp_b <= rxs;

      if (state == START)                bit_idx <= '0;
      else if (state == DATA && at_wrap) bit_idx <= bit_idx + 1'b1;

      if (state == DATA && at_dec) shift <= {vote, shift[DATA_BITS-1:1]};
      if (valid_set)               data_out <= shift;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && at_dec) par_bit <= vote;
      parity_err <= perr_set;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_8bit.sv
// Self-checking bench for uart_rx_8bit: directed vectors, multi-cycle corner cases and
// randomized frames compared against a frame-level reference model.
module tb_uart_rx_8bit;
  import uart_pkg::*;

  localparam int CPB     = 16;
  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_err, parity_err, busy;

  uart_rx_8bit #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] d;
    logic       stop_bit;
    logic       par_flip;
    int         exp_kind;
    logic [7:0] exp_data;
  } vec_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         ev_base = 0;
  ev_t        evq[$];
  ev_t        expq[$];
  vec_t       vecs[$];
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: logs every result pulse, sampled on the falling edge.
  always @(negedge clk) begin : monitor
    int n;
    if (rst_n) begin
      n = int'(valid) + int'(frame_err) + int'(parity_err);
      if (valid)      evq.push_back('{K_VALID, data_out, cyc});
      if (frame_err)  evq.push_back('{K_FERR, data_out, cyc});
      if (parity_err) evq.push_back('{K_PERR, data_out, cyc});
      if (n > 1) check("pulse_exclusive", n, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    tick(n);
  endtask

  // A spiked bit carries one inverted cycle at its nominal midpoint.
  task automatic send_bit(input logic b, input logic spike);
    rx = b;
    if (spike) begin
      tick(CPB / 2);
      rx = ~b;
      tick(1);
      rx = b;
      tick(CPB / 2 - 1);
    end else begin
      tick(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip,
                            input int spike_bit);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i], i == spike_bit);
    if (PAR_EN) send_bit((^d) ^ par_flip, 1'b0);
    send_bit(stop_bit, 1'b0);
  endtask

  // Reference model: classifies a whole frame from its fields.
  task automatic model_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
    if (!stop_bit) begin
      expq.push_back('{K_FERR, last_good, 0});
    end else if (PAR_EN && par_flip) begin
      expq.push_back('{K_PERR, last_good, 0});
    end else begin
      last_good = d;
      expq.push_back('{K_VALID, d, 0});
    end
  endtask

  task automatic compare_events(input string name);
    int got;
    got = evq.size() - ev_base;
    check({name, "_count"}, got, expq.size());
    for (int i = 0; i < expq.size() && i < got; i++) begin
      check($sformatf("%s_kind%0d", name, i), evq[ev_base + i].kind, expq[i].kind);
      check($sformatf("%s_data%0d", name, i), evq[ev_base + i].data, expq[i].data);
    end
    ev_base = evq.size();
    expq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       stop_bit, par_flip;
    int         t0;

    vecs.push_back('{8'h00, 1'b1, 1'b0, K_VALID, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, K_VALID, 8'hFF});
    vecs.push_back('{8'h5A, 1'b0, 1'b0, K_FERR,  8'hFF});
    vecs.push_back('{8'h81, 1'b1, 1'b0, K_VALID, 8'h81});
    vecs.push_back('{8'hC3, 1'b0, 1'b0, K_FERR,  8'h81});
    if (PAR_EN) begin
      vecs.push_back('{8'h12, 1'b1, 1'b1, K_PERR, 8'h81});
      vecs.push_back('{8'h12, 1'b0, 1'b1, K_FERR, 8'h81});
    end
    vecs.push_back('{8'h3C, 1'b1, 1'b0, K_VALID, 8'h3C});

    // Reset state
    rst_n = 1'b0;
    tick(4);
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(2 * CPB);

    // First byte and its latency from the start edge
    model_frame(8'h35, 1'b1, 1'b0);
    t0 = cyc;
    send_frame(8'h35, 1'b1, 1'b0, -1);
    idle(2 * CPB);
    if (evq.size() > ev_base) check_range("latency", evq[ev_base].cyc - t0, 155, 157);
    else check("latency_seen", 1'b0, 1'b1);
    compare_events("first_byte");

    // Directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      send_frame(vecs[i].d, vecs[i].stop_bit, vecs[i].par_flip, -1);
      idle(2 * CPB);
      check($sformatf("vec%0d_count", i), evq.size() - ev_base, 1);
      if (evq.size() > ev_base)
        check($sformatf("vec%0d_kind", i), evq[evq.size() - 1].kind, vecs[i].exp_kind);
      check($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp_data);
      ev_base = evq.size();
    end
    last_good = 8'h3C;

    // Back-to-back frames, no idle gap
    for (int i = 0; i < 10; i++) begin
      d = 8'h30 + 8'(i);
      model_frame(d, 1'b1, 1'b0);
      send_frame(d, 1'b1, 1'b0, -1);
    end
    idle(2 * CPB);
    compare_events("back_to_back");

    // Short low glitch on an idle line
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(10);
    check("glitch_busy", busy, 1'b0);
    idle(2 * CPB);
    compare_events("glitch");

    // Stop bit low, line held low: single frame error, then recovery
    model_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, -1);
    tick(40 * CPB);
    check("break_busy", busy, 1'b1);
    idle(2 * CPB);
    check("break_data_out", data_out, last_good);
    model_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'h41, 1'b1, 1'b0, -1);
    idle(2 * CPB);
    compare_events("break");

    // Mid-bit spike rejected by the vote
    model_frame(8'hA5, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 3);
    idle(2 * CPB);
    compare_events("spike");
    check("spike_data_out", data_out, 8'hA5);

    // Reset during bit 4 of 0x7E
    d = 8'h7E;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
    rx = d[4];
    tick(CPB / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    tick(3);
    check("midrst_busy", busy, 1'b0);
    rst_n = 1'b1;
    last_good = 8'h00;
    idle(2 * CPB);
    check("midrst_data_out", data_out, 8'h00);
    compare_events("midrst_abort");
    model_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0, -1);
    idle(2 * CPB);
    if (PAR_EN) begin
      model_frame(8'h12, 1'b1, 1'b1);
      send_frame(8'h12, 1'b1, 1'b1, -1);
      idle(2 * CPB);
    end
    compare_events("midrst_after");

    // Randomized frames against the model
    for (int i = 0; i < 40; i++) begin
      d        = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 5) != 0);
      par_flip = PAR_EN && ($urandom_range(0, 3) == 0);
      model_frame(d, stop_bit, par_flip);
      send_frame(d, stop_bit, par_flip, $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : -1);
      if (!stop_bit) idle(CPB + int'($urandom_range(0, 16)));
      else           idle(int'($urandom_range(0, 20)));
    end
    idle(2 * CPB);
    compare_events("random");
    check("random_data_out", data_out, last_good);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
